// File: rtl/decode_pkg.sv
// Shared opcode encodings, FSM states and scoreboard entry type for the decode/hazard stage.
package decode_pkg;

    localparam logic [4:0] OpHalt = 5'b00000;
    localparam logic [4:0] OpNop  = 5'b00001;
    localparam logic [4:0] OpSiic = 5'b00010;
    localparam logic [4:0] OpRti  = 5'b00011;
    localparam logic [4:0] OpJ    = 5'b00100;
    localparam logic [4:0] OpJr   = 5'b00101;
    localparam logic [4:0] OpJal  = 5'b00110;
    localparam logic [4:0] OpJalr = 5'b00111;
    localparam logic [4:0] OpSt   = 5'b10000;
    localparam logic [4:0] OpLd   = 5'b10001;
    localparam logic [4:0] OpSlbi = 5'b10010;
    localparam logic [4:0] OpStu  = 5'b10011;
    localparam logic [4:0] OpLbi  = 5'b11000;
    localparam logic [4:0] OpBtr  = 5'b11001;
    localparam logic [4:0] OpRa   = 5'b11010;
    localparam logic [4:0] OpRb   = 5'b11011;

    localparam logic [15:0] NopInstr  = 16'h0800;
    localparam logic [15:0] HaltInstr = 16'h0000;

    // Cycles spent in StHaltPend after the HALT enters ID/EX before declaring the pipe drained.
    localparam logic [1:0] HaltDrain = 2'd2;

    typedef enum logic [1:0] {
        StRun,
        StHaltPend,
        StHalted
    } state_e;

    typedef struct packed {
        logic       wr_en;
        logic [2:0] wr_reg;
    } sb_entry_t;

endpackage

// File: rtl/instr_fields.sv
// Combinational field decode: which source registers an instruction reads and what it writes.
module instr_fields
    import decode_pkg::*;
(
    input  logic [15:2] instr,
    output logic        use_rs,
    output logic        use_rt,
    output logic        wr_en,
    output logic [2:0]  wr_reg,
    output logic        illegal
);

    logic [4:0] opcode;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [2:0] rd;

    assign opcode = instr[15:11];
    assign rs     = instr[10:8];
    assign rt     = instr[7:5];
    assign rd     = instr[4:2];

    always_comb begin
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        wr_en   = 1'b0;
        wr_reg  = 3'd0;
        illegal = 1'b0;
        unique casez (opcode)
            OpHalt, OpNop, OpJ: ;
            OpSiic, OpRti: illegal = 1'b1;
            5'b010??, 5'b101??, OpLd: begin
                use_rs = 1'b1;
                wr_en  = 1'b1;
                wr_reg = rt;
            end
            OpSt: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            OpStu: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
                wr_en  = 1'b1;
                wr_reg = rs;
            end
            OpLbi: begin
                wr_en  = 1'b1;
                wr_reg = rs;
            end
            OpSlbi: begin
                use_rs = 1'b1;
                wr_en  = 1'b1;
                wr_reg = rs;
            end
            OpBtr: begin
                use_rs = 1'b1;
                wr_en  = 1'b1;
                wr_reg = rd;
            end
            OpRa, OpRb, 5'b111??: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
                wr_en  = 1'b1;
                wr_reg = rd;
            end
            5'b011??, OpJr: use_rs = 1'b1;
            OpJal: begin
                wr_en  = 1'b1;
                wr_reg = 3'd7;
            end
            OpJalr: begin
                use_rs = 1'b1;
                wr_en  = 1'b1;
                wr_reg = 3'd7;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_hazard_unit.sv
// Decode stage: RAW interlock against in-flight writers, branch squash, HALT drain and the
// ID/EX pipeline register. TRACK_DEPTH must be at least 2.
module decode_hazard_unit
    import decode_pkg::*;
#(
    parameter int unsigned TRACK_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr_IFID,
    input  logic [15:0] PC2_IFID,
    input  logic        halt_IFID,
    input  logic        takeBranch_EXMEM,
    output logic        stallCtrl,
    output logic [15:0] instr_IDEX,
    output logic [15:0] PC2_IDEX,
    output logic        valid_IDEX,
    output logic        wrEn_IDEX,
    output logic [2:0]  wrReg_IDEX,
    output logic        halt_IDEX,
    output logic        halted,
    output logic        err
);

    logic       use_rs;
    logic       use_rt;
    logic       dec_wr_en;
    logic [2:0] dec_wr_reg;
    logic       illegal;

    instr_fields u_instr_fields (
        .instr   (instr_IFID[15:2]),
        .use_rs  (use_rs),
        .use_rt  (use_rt),
        .wr_en   (dec_wr_en),
        .wr_reg  (dec_wr_reg),
        .illegal (illegal)
    );

    state_e                        state_q, state_d;
    logic [1:0]                    cnt_q, cnt_d;
    sb_entry_t [TRACK_DEPTH-1:0]   sb_q;
    sb_entry_t                     issue_entry;
    logic                          hazard;
    logic                          issue;

    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < TRACK_DEPTH; i++) begin
            if (sb_q[i].wr_en &&
                ((use_rs && sb_q[i].wr_reg == instr_IFID[10:8]) ||
                 (use_rt && sb_q[i].wr_reg == instr_IFID[7:5]))) begin
                hazard = 1'b1;
            end
        end
    end

    assign issue = (state_q == StRun) && !hazard && !takeBranch_EXMEM;

    always_comb begin
        issue_entry = '0;
        if (issue) begin
            issue_entry.wr_en  = dec_wr_en;
            issue_entry.wr_reg = dec_wr_reg;
        end
    end

    // A taken branch squashes both younger slots; the EX/MEM writer shifts out to MEM/WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q <= '0;
        end else if (takeBranch_EXMEM) begin
            sb_q <= '0;
        end else begin
            sb_q <= {sb_q[TRACK_DEPTH-2:0], issue_entry};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRun: begin
                if (issue && halt_IFID) begin
                    state_d = StHaltPend;
                    cnt_d   = HaltDrain;
                end
            end
            StHaltPend: begin
                // Only the first pending cycle has the HALT still squashable in ID/EX.
                if (takeBranch_EXMEM && cnt_q == HaltDrain) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = StHalted;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StHalted: ;
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        stallCtrl = hazard && (state_q == StRun) && !takeBranch_EXMEM;
        halted    = (state_q == StHalted);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_IDEX <= NopInstr;
            PC2_IDEX   <= '0;
            valid_IDEX <= 1'b0;
            wrEn_IDEX  <= 1'b0;
            wrReg_IDEX <= '0;
            halt_IDEX  <= 1'b0;
            err        <= 1'b0;
        end else if (issue) begin
            instr_IDEX <= instr_IFID;
            PC2_IDEX   <= PC2_IFID;
            valid_IDEX <= 1'b1;
            wrEn_IDEX  <= dec_wr_en;
            wrReg_IDEX <= dec_wr_reg;
            halt_IDEX  <= halt_IFID;
            err        <= illegal;
        end else begin
            instr_IDEX <= NopInstr;
            valid_IDEX <= 1'b0;
            wrEn_IDEX  <= 1'b0;
            wrReg_IDEX <= '0;
            halt_IDEX  <= 1'b0;
            err        <= 1'b0;
        end
    end

endmodule
